caliptra_axil_apb_bridge: RTL and testbench

AXI4-Lite slave to APB master bridge that sits directly upstream of the Caliptra APB wrapper top in the FPGA build. It turns single-beat AXI4-Lite reads and writes from the processing-system interconnect into APB transfers on the 40-bit `s_apb_*` port of the Caliptra package. One transfer is in flight at a time. A PREADY timeout stops a hung Caliptra from stalling the AXI fabric.

---
 rtl/caliptra_fpga_bridge_pkg.sv | 23 ++
 rtl/caliptra_axil_apb_bridge_if.sv | 50 +++++
 rtl/caliptra_axil_apb_bridge.sv | 131 +++++++++++++
 tb/tb_caliptra_axil_apb_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/caliptra_fpga_bridge_pkg.sv
// rtl/caliptra_fpga_bridge_pkg.sv - shared types for the Caliptra AXI4-Lite to APB bridge
package caliptra_fpga_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WRESP,
        ST_RRESP
    } bridge_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        is_write;
    } bridge_req_t;

endpackage

// File: rtl/caliptra_axil_apb_bridge_if.sv
// rtl/caliptra_axil_apb_bridge_if.sv - AXI4-Lite slave and APB master signal bundle
interface caliptra_axil_apb_bridge_if #(
    parameter int APB_ADDR_WIDTH = 40,
    parameter int DATA_WIDTH     = 32
);
    logic                      S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0]               S_AXI_AWADDR;
    logic [2:0]                S_AXI_AWPROT;
    logic                      S_AXI_WVALID, S_AXI_WREADY;
    logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                      S_AXI_BVALID, S_AXI_BREADY;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0]               S_AXI_ARADDR;
    logic [2:0]                S_AXI_ARPROT;
    logic                      S_AXI_RVALID, S_AXI_RREADY;
    logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic [APB_ADDR_WIDTH-1:0] m_apb_paddr;
    logic [2:0]                m_apb_pprot;
    logic [DATA_WIDTH/8-1:0]   m_apb_pstrb;
    logic                      m_apb_psel, m_apb_penable, m_apb_pwrite;
    logic [DATA_WIDTH-1:0]     m_apb_pwdata;
    logic [DATA_WIDTH-1:0]     m_apb_prdata;
    logic                      m_apb_pready, m_apb_pslverr;

    // Bridge view: AXI-Lite completer upstream, APB requester downstream.
    modport slave (
        input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
        input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_BREADY,
        input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_RREADY,
        input  m_apb_prdata, m_apb_pready, m_apb_pslverr,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
        output S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
        output m_apb_paddr, m_apb_pprot, m_apb_pstrb, m_apb_psel,
        output m_apb_penable, m_apb_pwrite, m_apb_pwdata
    );

    modport master (
        output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
        output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_BREADY,
        output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_RREADY,
        output m_apb_prdata, m_apb_pready, m_apb_pslverr,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
        input  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
        input  m_apb_paddr, m_apb_pprot, m_apb_pstrb, m_apb_psel,
        input  m_apb_penable, m_apb_pwrite, m_apb_pwdata
    );
endinterface

// File: rtl/caliptra_axil_apb_bridge.sv
// rtl/caliptra_axil_apb_bridge.sv - single-outstanding AXI4-Lite to APB bridge with PREADY timeout
module caliptra_axil_apb_bridge
    import caliptra_fpga_bridge_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 40,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                       core_clk,
    input logic                       core_rst,
    caliptra_axil_apb_bridge_if.slave bus
);
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_e         state, state_next;
    bridge_req_t           req_q, req_sel;
    logic                  aw_full, w_full, ar_full;
    logic [31:0]           aw_addr, ar_addr;
    logic [2:0]            aw_prot, ar_prot;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic                  last_write;
    logic [CNT_W-1:0]      to_cnt;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic aw_hs, w_hs, ar_hs, wr_pend, rd_pend, grant_write;
    logic timed_out, access_done, start;

    assign bus.S_AXI_AWREADY = !core_rst && !aw_full;
    assign bus.S_AXI_WREADY  = !core_rst && !w_full;
    // AR stays closed while a read response is still waiting for RREADY.
    assign bus.S_AXI_ARREADY = !core_rst && !ar_full && (state != ST_RRESP);

    assign aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
    assign w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
    assign ar_hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;

    // Same-cycle handshakes count so a request reaches SETUP on the next edge.
    assign wr_pend     = (aw_full || aw_hs) && (w_full || w_hs);
    assign rd_pend     = ar_full || ar_hs;
    assign grant_write = wr_pend && (!rd_pend || !last_write);
    assign start       = (state == ST_IDLE) && (wr_pend || rd_pend);

    assign timed_out   = !bus.m_apb_pready && (to_cnt == CNT_LAST);
    assign access_done = (state == ST_ACCESS) && (bus.m_apb_pready || timed_out);

    always_comb begin
        req_sel = '0;
        if (grant_write) begin
            req_sel.addr     = aw_full ? aw_addr : bus.S_AXI_AWADDR;
            req_sel.prot     = aw_full ? aw_prot : bus.S_AXI_AWPROT;
            req_sel.data     = w_full ? w_data : bus.S_AXI_WDATA;
            req_sel.strb     = w_full ? w_strb : bus.S_AXI_WSTRB;
            req_sel.is_write = 1'b1;
        end else begin
            req_sel.addr = ar_full ? ar_addr : bus.S_AXI_ARADDR;
            req_sel.prot = ar_full ? ar_prot : bus.S_AXI_ARPROT;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (access_done) state_next = req_q.is_write ? ST_WRESP : ST_RRESP;
            ST_WRESP:  if (bus.S_AXI_BREADY) state_next = ST_IDLE;
            ST_RRESP:  if (bus.S_AXI_RREADY) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            aw_full <= 1'b0; w_full <= 1'b0; ar_full <= 1'b0;
            aw_addr <= '0; aw_prot <= '0; w_data <= '0; w_strb <= '0;
            ar_addr <= '0; ar_prot <= '0;
            req_q <= '0; last_write <= 1'b0; to_cnt <= '0;
            bresp_q <= AXI_RESP_OKAY; rresp_q <= AXI_RESP_OKAY; rdata_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1; aw_addr <= bus.S_AXI_AWADDR; aw_prot <= bus.S_AXI_AWPROT;
            end
            if (w_hs) begin
                w_full <= 1'b1; w_data <= bus.S_AXI_WDATA; w_strb <= bus.S_AXI_WSTRB;
            end
            if (ar_hs) begin
                ar_full <= 1'b1; ar_addr <= bus.S_AXI_ARADDR; ar_prot <= bus.S_AXI_ARPROT;
            end
            if (start) begin
                req_q      <= req_sel;
                last_write <= grant_write;
            end
            if (state == ST_SETUP)       to_cnt <= '0;
            else if (state == ST_ACCESS) to_cnt <= to_cnt + 1'b1;
            // Holding slots free on completion so the next request can queue behind the response.
            if (access_done) begin
                if (req_q.is_write) begin
                    aw_full <= 1'b0;
                    w_full  <= 1'b0;
                    bresp_q <= (timed_out || bus.m_apb_pslverr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                end else begin
                    ar_full <= 1'b0;
                    rresp_q <= (timed_out || bus.m_apb_pslverr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    rdata_q <= timed_out ? '0 : bus.m_apb_prdata;
                end
            end
        end
    end

    assign bus.S_AXI_BVALID  = (state == ST_WRESP);
    assign bus.S_AXI_BRESP   = bresp_q;
    assign bus.S_AXI_RVALID  = (state == ST_RRESP);
    assign bus.S_AXI_RRESP   = rresp_q;
    assign bus.S_AXI_RDATA   = rdata_q;
    assign bus.m_apb_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
    assign bus.m_apb_penable = (state == ST_ACCESS);
    assign bus.m_apb_paddr   = APB_ADDR_WIDTH'(req_q.addr);
    assign bus.m_apb_pprot   = req_q.prot;
    assign bus.m_apb_pstrb   = req_q.strb;
    assign bus.m_apb_pwrite  = req_q.is_write;
    assign bus.m_apb_pwdata  = req_q.data;

endmodule

// File: tb/tb_caliptra_axil_apb_bridge.sv
// tb/tb_caliptra_axil_apb_bridge.sv - directed self-checking bench for the AXI4-Lite to APB bridge
module tb_caliptra_axil_apb_bridge;
    import caliptra_fpga_bridge_pkg::*;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    always #5 core_clk = ~core_clk;

    caliptra_axil_apb_bridge_if #(.APB_ADDR_WIDTH(40), .DATA_WIDTH(32)) bus ();

    caliptra_axil_apb_bridge #(
        .APB_ADDR_WIDTH(40),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .core_clk(core_clk),
        .core_rst(core_rst),
        .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int access_cnt = 0;
    bit psel_seen = 0;
    bit bvalid_seen = 0;
    logic is_wr;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples 1 time unit after the active edge so the initial block never races it.
    always @(posedge core_clk) begin
        #1;
        if (bus.m_apb_psel && bus.m_apb_penable) access_cnt++;
        if (bus.m_apb_psel) psel_seen = 1;
        if (bus.S_AXI_BVALID) bvalid_seen = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge core_clk);
    endtask

    task automatic send_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [2:0] prot);
        bus.S_AXI_AWVALID = 1; bus.S_AXI_AWADDR = addr; bus.S_AXI_AWPROT = prot;
        bus.S_AXI_WVALID = 1; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
        cyc();
        bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    endtask

    task automatic send_read(input logic [31:0] addr, input logic [2:0] prot);
        bus.S_AXI_ARVALID = 1; bus.S_AXI_ARADDR = addr; bus.S_AXI_ARPROT = prot;
        cyc();
        bus.S_AXI_ARVALID = 0;
    endtask

    task automatic wait_setup(input string tag, output logic wr);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.m_apb_psel && !bus.m_apb_penable) found = 1;
            else cyc();
        end
        expect_eq({tag, "_setup_seen"}, found, 1);
        wr = bus.m_apb_pwrite;
    endtask

    task automatic finish_write(input string tag, input logic [1:0] resp);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.S_AXI_BVALID) found = 1;
            else cyc();
        end
        expect_eq({tag, "_bvalid"}, found, 1);
        expect_eq({tag, "_bresp"}, bus.S_AXI_BRESP, resp);
        bus.S_AXI_BREADY = 1;
        cyc();
        bus.S_AXI_BREADY = 0;
    endtask

    task automatic finish_read(input string tag, input logic [1:0] resp, input logic [31:0] data);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.S_AXI_RVALID) found = 1;
            else cyc();
        end
        expect_eq({tag, "_rvalid"}, found, 1);
        expect_eq({tag, "_rresp"}, bus.S_AXI_RRESP, resp);
        expect_eq({tag, "_rdata"}, bus.S_AXI_RDATA, data);
        bus.S_AXI_RREADY = 1;
        cyc();
        bus.S_AXI_RREADY = 0;
    endtask

    initial begin
        bus.S_AXI_AWVALID = 0; bus.S_AXI_AWADDR = 0; bus.S_AXI_AWPROT = 0;
        bus.S_AXI_WVALID = 0; bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0;
        bus.S_AXI_BREADY = 0; bus.S_AXI_ARVALID = 0; bus.S_AXI_ARADDR = 0;
        bus.S_AXI_ARPROT = 0; bus.S_AXI_RREADY = 0;
        bus.m_apb_prdata = 0; bus.m_apb_pready = 1; bus.m_apb_pslverr = 0;

        // Reset values
        repeat (2) cyc();
        expect_eq("rst_awready", bus.S_AXI_AWREADY, 0);
        expect_eq("rst_wready", bus.S_AXI_WREADY, 0);
        expect_eq("rst_arready", bus.S_AXI_ARREADY, 0);
        expect_eq("rst_bvalid", bus.S_AXI_BVALID, 0);
        expect_eq("rst_rvalid", bus.S_AXI_RVALID, 0);
        expect_eq("rst_psel", bus.m_apb_psel, 0);
        expect_eq("rst_penable", bus.m_apb_penable, 0);
        expect_eq("rst_pwrite", bus.m_apb_pwrite, 0);
        expect_eq("rst_paddr", bus.m_apb_paddr, 0);
        expect_eq("rst_rdata", bus.S_AXI_RDATA, 0);
        core_rst = 0;
        cyc();
        expect_eq("post_rst_awready", bus.S_AXI_AWREADY, 1);

        // Zero-wait write: SETUP at N+1, ACCESS at N+2, BVALID at N+3
        send_write(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010);
        expect_eq("zw_setup_psel", bus.m_apb_psel, 1);
        expect_eq("zw_setup_penable", bus.m_apb_penable, 0);
        expect_eq("zw_paddr", bus.m_apb_paddr, 40'h00_3000_0010);
        expect_eq("zw_pwrite", bus.m_apb_pwrite, 1);
        expect_eq("zw_pwdata", bus.m_apb_pwdata, 32'hDEAD_BEEF);
        expect_eq("zw_pstrb", bus.m_apb_pstrb, 4'hF);
        expect_eq("zw_pprot", bus.m_apb_pprot, 3'b010);
        cyc();
        expect_eq("zw_access_penable", bus.m_apb_penable, 1);
        expect_eq("zw_access_paddr", bus.m_apb_paddr, 40'h00_3000_0010);
        cyc();
        expect_eq("zw_n3_bvalid", bus.S_AXI_BVALID, 1);
        expect_eq("zw_n3_psel", bus.m_apb_psel, 0);
        finish_write("zw", AXI_RESP_OKAY);

        // Wait-state read: three ACCESS cycles with pready low
        bus.m_apb_pready = 0;
        send_read(32'h3000_0020, 3'b001);
        expect_eq("ws_setup_psel", bus.m_apb_psel, 1);
        expect_eq("ws_pwrite", bus.m_apb_pwrite, 0);
        expect_eq("ws_pstrb", bus.m_apb_pstrb, 0);
        expect_eq("ws_paddr", bus.m_apb_paddr, 40'h00_3000_0020);
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_eq("ws_wait_penable", bus.m_apb_penable, 1);
        end
        cyc();
        expect_eq("ws_last_penable", bus.m_apb_penable, 1);
        bus.m_apb_pready = 1; bus.m_apb_prdata = 32'h1234_5678;
        cyc();
        bus.m_apb_prdata = 32'hFFFF_0000;
        expect_eq("ws_rvalid", bus.S_AXI_RVALID, 1);
        expect_eq("ws_arready_blocked", bus.S_AXI_ARREADY, 0);
        cyc();
        expect_eq("ws_hold_rvalid", bus.S_AXI_RVALID, 1);
        expect_eq("ws_hold_rdata", bus.S_AXI_RDATA, 32'h1234_5678);
        finish_read("ws", AXI_RESP_OKAY, 32'h1234_5678);
        expect_eq("ws_arready_free", bus.S_AXI_ARREADY, 1);

        // W four cycles ahead of AW
        bus.S_AXI_WVALID = 1; bus.S_AXI_WDATA = 32'hCAFE_F00D; bus.S_AXI_WSTRB = 4'h3;
        cyc();
        bus.S_AXI_WVALID = 0;
        psel_seen = 0;
        repeat (4) cyc();
        expect_eq("wfirst_no_apb", psel_seen, 0);
        expect_eq("wfirst_wready", bus.S_AXI_WREADY, 0);
        bus.S_AXI_AWVALID = 1; bus.S_AXI_AWADDR = 32'h3000_0040; bus.S_AXI_AWPROT = 3'b000;
        cyc();
        bus.S_AXI_AWVALID = 0;
        expect_eq("wfirst_psel", bus.m_apb_psel, 1);
        expect_eq("wfirst_paddr", bus.m_apb_paddr, 40'h00_3000_0040);
        expect_eq("wfirst_pwdata", bus.m_apb_pwdata, 32'hCAFE_F00D);
        expect_eq("wfirst_pstrb", bus.m_apb_pstrb, 4'h3);
        finish_write("wfirst", AXI_RESP_OKAY);

        // Simultaneous read and write straight after reset: write first
        core_rst = 1;
        repeat (2) cyc();
        core_rst = 0;
        cyc();
        bus.S_AXI_ARVALID = 1; bus.S_AXI_ARADDR = 32'h3000_0100; bus.S_AXI_ARPROT = 0;
        send_write(32'h3000_0104, 32'h0000_0001, 4'hF, 3'b000);
        bus.S_AXI_ARVALID = 0;
        wait_setup("pair1_first", is_wr);
        expect_eq("pair1_first_is_write", is_wr, 1);
        expect_eq("pair1_first_paddr", bus.m_apb_paddr, 40'h00_3000_0104);
        finish_write("pair1_w", AXI_RESP_OKAY);
        bus.m_apb_prdata = 32'h0000_0AAA;
        wait_setup("pair1_second", is_wr);
        expect_eq("pair1_second_is_write", is_wr, 0);
        expect_eq("pair1_second_paddr", bus.m_apb_paddr, 40'h00_3000_0100);
        finish_read("pair1_r", AXI_RESP_OKAY, 32'h0000_0AAA);

        // A lone write makes write the last-served side, so the next pair goes read first
        send_write(32'h3000_0108, 32'h0000_0002, 4'hF, 3'b000);
        finish_write("lone_w", AXI_RESP_OKAY);
        bus.S_AXI_ARVALID = 1; bus.S_AXI_ARADDR = 32'h3000_0200; bus.S_AXI_ARPROT = 0;
        send_write(32'h3000_0204, 32'h0000_0003, 4'hF, 3'b000);
        bus.S_AXI_ARVALID = 0;
        bus.m_apb_prdata = 32'h0000_0BBB;
        wait_setup("pair2_first", is_wr);
        expect_eq("pair2_first_is_write", is_wr, 0);
        finish_read("pair2_r", AXI_RESP_OKAY, 32'h0000_0BBB);
        wait_setup("pair2_second", is_wr);
        expect_eq("pair2_second_is_write", is_wr, 1);
        expect_eq("pair2_second_pwdata", bus.m_apb_pwdata, 32'h0000_0003);
        finish_write("pair2_w", AXI_RESP_OKAY);

        // PSLVERR on a read, then a clean write
        bus.m_apb_pslverr = 1; bus.m_apb_prdata = 32'h0BAD_0BAD;
        send_read(32'h3000_0300, 3'b000);
        finish_read("slverr", AXI_RESP_SLVERR, 32'h0BAD_0BAD);
        bus.m_apb_pslverr = 0;
        send_write(32'h3000_0304, 32'h0000_0004, 4'h1, 3'b000);
        finish_write("after_slverr", AXI_RESP_OKAY);

        // Timeout: exactly 8 ACCESS cycles then SLVERR
        bus.m_apb_pready = 0;
        access_cnt = 0;
        send_write(32'h3000_0400, 32'h0000_0005, 4'hF, 3'b000);
        finish_write("timeout", AXI_RESP_SLVERR);
        expect_eq("timeout_access_cycles", access_cnt, 8);
        expect_eq("timeout_psel_low", bus.m_apb_psel, 0);

        // Reset in the middle of ACCESS
        send_write(32'h3000_0500, 32'h0000_0006, 4'hF, 3'b000);
        cyc();
        cyc();
        expect_eq("midrst_in_access", bus.m_apb_penable, 1);
        core_rst = 1;
        cyc();
        expect_eq("midrst_psel", bus.m_apb_psel, 0);
        expect_eq("midrst_penable", bus.m_apb_penable, 0);
        core_rst = 0;
        psel_seen = 0; bvalid_seen = 0;
        repeat (4) cyc();
        expect_eq("midrst_no_bvalid", bvalid_seen, 0);
        expect_eq("midrst_no_replay", psel_seen, 0);
        bus.m_apb_pready = 1; bus.m_apb_prdata = 32'hA5A5_0001;
        send_read(32'h3000_0600, 3'b000);
        finish_read("midrst_fresh", AXI_RESP_OKAY, 32'hA5A5_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
